// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: synchronous PS/2 deserializer folding E0/F0 prefixes into key events with a valid/ack handshake.
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2_Clock,
    input  logic       PS2_Data,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_ext,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic clk_f_q, clk_f_d;
    logic [FW-1:0] flt_q, flt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic par_q, par_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0] code_q, code_d;
    logic is_break_q, is_break_d, is_ext_q, is_ext_d, valid_q, valid_d;
    logic frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic fall, err, byte_done, timeout, is_e0, is_f0, ev;

    // Filtered clock flips only after FILTER_LEN consecutive samples of the new level.
    always_comb begin
        flt_d   = '0;
        clk_f_d = clk_f_q;
        if (clk_s2_q != clk_f_q) begin
            if (flt_q == FW'(FILTER_LEN - 1)) clk_f_d = clk_s2_q;
            else flt_d = flt_q + 1'b1;
        end
        fall    = clk_f_q & ~clk_f_d;
        timeout = (state_q != IDLE) && !fall && (to_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
        to_d    = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        err       = 1'b0;
        byte_done = 1'b0;
        if (timeout) begin
            err     = 1'b1;
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (dat_s2_q) err = 1'b1;
                    else begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^shift_q ^ par_q)) byte_done = 1'b1;
                    else err = 1'b1;
                end
            endcase
        end
    end

    // Prefix bytes only arm pend flags; any other byte or an error consumes them.
    always_comb begin
        is_e0       = shift_q == 8'hE0;
        is_f0       = shift_q == 8'hF0;
        ev          = byte_done && !is_e0 && !is_f0;
        ext_pend_d  = (err || ev) ? 1'b0 : (byte_done && is_e0) ? 1'b1 : ext_pend_q;
        brk_pend_d  = (err || ev) ? 1'b0 : (byte_done && is_f0) ? 1'b1 : brk_pend_q;
        code_d      = code_q;
        is_break_d  = is_break_q;
        is_ext_d    = is_ext_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = err;
        if (ev && (!valid_q || ack)) begin
            code_d     = shift_q;
            is_break_d = brk_pend_q;
            is_ext_d   = ext_pend_q;
            valid_d    = 1'b1;
        end else if (ev) begin
            overrun_d = 1'b1;
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            clk_f_q     <= 1'b1;
            flt_q       <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_q        <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            code_q      <= 8'h00;
            is_break_q  <= 1'b0;
            is_ext_q    <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            clk_s1_q    <= PS2_Clock;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= PS2_Data;
            dat_s2_q    <= dat_s1_q;
            clk_f_q     <= clk_f_d;
            flt_q       <= flt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_q        <= to_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            code_q      <= code_d;
            is_break_q  <= is_break_d;
            is_ext_q    <= is_ext_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign code      = code_q;
    assign is_break  = is_break_q;
    assign is_ext    = is_ext_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: directed PS/2 frames with hand-computed parity and expected events.
module tb_ps2_frame_receiver;
    localparam int FL = 4;
    localparam int TO = 300;
    localparam int TW = 9;
    localparam int H  = 20;

    logic clk = 1'b0, rst_n = 1'b0, PS2_Clock = 1'b1, PS2_Data = 1'b1, ack = 1'b0;
    logic [7:0] code;
    logic is_break, is_ext, valid, frame_err, overrun;
    int pass = 0, total = 0;
    int cyc = 0, err_cnt = 0, ovr_cnt = 0, ev_cnt = 0;
    int err_t = 0, ovr_t = 0, stop_t = 0, fall_t = 0;
    logic valid_prev = 1'b0;

    ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .PS2_Clock(PS2_Clock), .PS2_Data(PS2_Data),
        .code(code), .is_break(is_break), .is_ext(is_ext), .valid(valid), .ack(ack),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin err_cnt++; err_t = cyc; end
        if (overrun === 1'b1) begin ovr_cnt++; ovr_t = cyc; end
        if (valid === 1'b1 && valid_prev !== 1'b1) ev_cnt++;
        valid_prev = valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // bits[0] is the start bit; ack pulses for one cycle ack_at cycles into the stop-bit low phase.
    task automatic send_bits(input logic [10:0] bits, input int n, input int ack_at);
        for (int i = 0; i < n; i++) begin
            PS2_Data = bits[i];
            wait_cyc(H);
            PS2_Clock = 1'b0;
            fall_t = cyc;
            if (i == 10) stop_t = cyc;
            for (int j = 0; j < H; j++) begin
                ack = (i == 10 && j == ack_at);
                @(negedge clk);
            end
            ack = 1'b0;
            PS2_Clock = 1'b1;
        end
        PS2_Data = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p);
        send_bits({1'b1, p, b, 1'b0}, 11, -1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        wait_cyc(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        wait_cyc(3);
        total++; if (code !== 8'h00) $display("FAIL reset_code got %h exp 00", code); else pass++;
        total++; if ({is_break, is_ext, valid, frame_err, overrun} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {is_break, is_ext, valid, frame_err, overrun}); else pass++;
        rst_n = 1'b1;
        wait_cyc(30);
        total++; if (err_cnt !== 0 || valid !== 1'b0) $display("FAIL reset_release err_cnt %0d valid %b exp 0 0", err_cnt, valid); else pass++;
    endtask

    task automatic test_basic();
        logic ok = 1'b1;
        send_frame(8'h69, 1'b1);
        total++; if (valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", valid); else pass++;
        total++; if (code !== 8'h69) $display("FAIL basic_code got %h exp 69", code); else pass++;
        total++; if ({is_break, is_ext} !== 2'b00) $display("FAIL basic_flags got %b exp 00", {is_break, is_ext}); else pass++;
        for (int i = 0; i < 100; i++) begin
            if (valid !== 1'b1 || code !== 8'h69 || is_break !== 1'b0 || is_ext !== 1'b0) ok = 1'b0;
            wait_cyc(1);
        end
        total++; if (ok !== 1'b1) $display("FAIL basic_hold got unstable exp stable"); else pass++;
        do_ack();
        total++; if (valid !== 1'b0) $display("FAIL basic_ack_drop got %b exp 0", valid); else pass++;
        total++; if (ev_cnt !== 1) $display("FAIL basic_events got %0d exp 1", ev_cnt); else pass++;
    endtask

    task automatic test_prefix();
        int e0 = ev_cnt;
        send_frame(8'hF0, 1'b1);
        send_frame(8'h69, 1'b1);
        total++; if (ev_cnt - e0 !== 1) $display("FAIL brk_events got %0d exp 1", ev_cnt - e0); else pass++;
        total++; if ({code, is_break, is_ext} !== {8'h69, 2'b10}) $display("FAIL brk_event got %h/%b%b exp 69/10", code, is_break, is_ext); else pass++;
        do_ack();
        e0 = ev_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h6B, 1'b0);
        total++; if (ev_cnt - e0 !== 1) $display("FAIL ext_brk_events got %0d exp 1", ev_cnt - e0); else pass++;
        total++; if ({code, is_break, is_ext} !== {8'h6B, 2'b11}) $display("FAIL ext_brk_event got %h/%b%b exp 6B/11", code, is_break, is_ext); else pass++;
        do_ack();
    endtask

    task automatic test_errors();
        int e0 = err_cnt;
        send_frame(8'h70, 1'b1);
        total++; if (err_cnt - e0 !== 1 || valid !== 1'b0) $display("FAIL parity_err errs %0d valid %b exp 1 0", err_cnt - e0, valid); else pass++;
        send_frame(8'hF0, 1'b1);
        send_frame(8'h70, 1'b0);
        total++; if ({valid, code, is_break, is_ext} !== {1'b1, 8'h70, 2'b10}) $display("FAIL after_parity got %b/%h/%b%b exp 1/70/10", valid, code, is_break, is_ext); else pass++;
        do_ack();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h70, 1'b1);
        send_frame(8'h70, 1'b0);
        total++; if ({valid, code, is_break, is_ext} !== {1'b1, 8'h70, 2'b00}) $display("FAIL err_clears_pend got %b/%h/%b%b exp 1/70/00", valid, code, is_break, is_ext); else pass++;
        do_ack();
        e0 = err_cnt;
        send_bits(11'h7FF, 1, -1);
        total++; if (err_cnt - e0 !== 1 || valid !== 1'b0) $display("FAIL start_err errs %0d valid %b exp 1 0", err_cnt - e0, valid); else pass++;
        send_frame(8'h7A, 1'b0);
        total++; if ({valid, code} !== {1'b1, 8'h7A}) $display("FAIL after_start_err got %b/%h exp 1/7A", valid, code); else pass++;
        do_ack();
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        int dt;
        send_bits({1'b1, 1'b0, 8'h7A, 1'b0}, 5, -1);
        for (int i = 0; i < 4 * TO && err_cnt == e0; i++) wait_cyc(1);
        dt = err_t - fall_t;
        total++; if (err_cnt - e0 !== 1 || dt < TO + 4 || dt > TO + 10) $display("FAIL timeout errs %0d delay %0d exp 1 and %0d..%0d", err_cnt - e0, dt, TO + 4, TO + 10); else pass++;
        send_frame(8'h7A, 1'b0);
        total++; if ({valid, code, is_break, is_ext} !== {1'b1, 8'h7A, 2'b00}) $display("FAIL after_timeout got %b/%h/%b%b exp 1/7A/00", valid, code, is_break, is_ext); else pass++;
        do_ack();
    endtask

    task automatic test_overrun();
        int o0 = ovr_cnt;
        int lat;
        send_frame(8'h70, 1'b0);
        send_frame(8'h7A, 1'b0);
        lat = ovr_t - stop_t;
        total++; if (ovr_cnt - o0 !== 1) $display("FAIL overrun_count got %0d exp 1", ovr_cnt - o0); else pass++;
        total++; if ({valid, code} !== {1'b1, 8'h70}) $display("FAIL overrun_hold got %b/%h exp 1/70", valid, code); else pass++;
        do_ack();
        send_frame(8'h70, 1'b0);
        o0 = ovr_cnt;
        if (lat < 1 || lat >= H) lat = 1;
        send_bits({1'b1, 1'b0, 8'h7A, 1'b0}, 11, lat - 1);
        total++; if (ovr_cnt !== o0) $display("FAIL ack_same_cycle overrun %0d exp 0", ovr_cnt - o0); else pass++;
        total++; if ({valid, code} !== {1'b1, 8'h7A}) $display("FAIL ack_same_cycle got %b/%h exp 1/7A", valid, code); else pass++;
        do_ack();
    endtask

    task automatic test_glitch_reset();
        int e0 = err_cnt;
        PS2_Clock = 1'b0; wait_cyc(2); PS2_Clock = 1'b1; wait_cyc(40);
        PS2_Clock = 1'b0; wait_cyc(FL - 1); PS2_Clock = 1'b1; wait_cyc(40);
        total++; if (err_cnt !== e0 || valid !== 1'b0) $display("FAIL glitch errs %0d valid %b exp 0 0", err_cnt - e0, valid); else pass++;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h6B, 1'b0);
        send_bits({1'b1, 1'b1, 8'h69, 1'b0}, 4, -1);
        PS2_Clock = 1'b0;
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        total++; if ({valid, code, is_break, is_ext, frame_err, overrun} !== 13'b0) $display("FAIL async_reset got %b/%h/%b%b%b%b exp 0/00/0000", valid, code, is_break, is_ext, frame_err, overrun); else pass++;
        PS2_Clock = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(TO + 50);
        send_frame(8'h69, 1'b1);
        total++; if ({valid, code, is_break, is_ext} !== {1'b1, 8'h69, 2'b00}) $display("FAIL after_reset got %b/%h/%b%b exp 1/69/00", valid, code, is_break, is_ext); else pass++;
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_errors();
        test_timeout();
        test_overrun();
        test_glitch_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
